// File: rtl/rmt_pkg.sv
// rmt_pkg: shared constants and types for the RMT packet rewrite pipeline.
//   - byte offsets of the first-beat header fields the parser looks at
//   - act_entry_t: one action-table entry (valid, byte offset, 32-bit value)
//   - get_byte(): pulls wire byte n out of a 512-bit beat
`timescale 1ns/1ps
package rmt_pkg;

  localparam int TPID_OFF      = 12;
  localparam int VID_OFF       = 14;
  localparam int ETYPE_OFF     = 16;
  localparam int PROTO_OFF     = 27;
  localparam int UDP_DPORT_OFF = 40;
  localparam int CTRL_MOD_OFF  = 42;
  localparam int CTRL_RES_OFF  = 43;
  localparam int CTRL_IDX_OFF  = 44;

  typedef struct packed {
    logic        valid;
    logic [5:0]  offset;
    logic [31:0] value;
  } act_entry_t;

  // Byte 0 is the first byte on the wire and sits in the low bits.
  function automatic logic [7:0] get_byte(input logic [511:0] d, input int n);
    return d[8*n +: 8];
  endfunction

endpackage

// File: rtl/rmt_pipeline_wrapper_if.sv
// axis_if: AXI4-Stream bundle (tdata/tkeep/tuser/tvalid/tready/tlast).
//   master modport drives payload + tvalid, samples tready;
//   slave modport is the mirror image.
`timescale 1ns/1ps
interface axis_if #(
  parameter int DW = 512,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_pipeline_wrapper_skid.sv
// axis_skid_buffer: 2-entry AXI4-Stream register slice (output register plus
// one spare slot). Full throughput, registered tready, no combinational path
// from m.tready to s.tready.
//   clk, rst_n : clock, async active-low reset
//   s          : upstream stream (slave side)
//   m          : downstream stream (master side)
`timescale 1ns/1ps
module axis_skid_buffer #(
  parameter int DW = 512,
  parameter int UW = 128
) (
  input  logic   clk,
  input  logic   rst_n,
  axis_if.slave  s,
  axis_if.master m
);
  localparam int PW = DW + DW/8 + UW + 1;

  logic [PW-1:0] out_q, out_d, sp_q, sp_d, in_pl;
  logic          out_vld_q, out_vld_d, sp_vld_q, sp_vld_d, rdy_q, rdy_d;
  logic          in_fire, out_free;

  assign in_pl    = {s.tdata, s.tkeep, s.tuser, s.tlast};
  assign in_fire  = s.tvalid & rdy_q;
  assign out_free = ~out_vld_q | m.tready;

  assign {m.tdata, m.tkeep, m.tuser, m.tlast} = out_q;
  assign m.tvalid = out_vld_q;
  assign s.tready = rdy_q;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sp_d      = sp_q;
    sp_vld_d  = sp_vld_q;
    if (out_free) begin
      // rdy_q mirrors an empty spare, so a parked beat and a new beat never
      // compete for the output register in the same cycle.
      if (sp_vld_q) begin
        out_d     = sp_q;
        out_vld_d = 1'b1;
        sp_vld_d  = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_d = in_pl;
      end
    end else if (in_fire) begin
      sp_d     = in_pl;
      sp_vld_d = 1'b1;
    end
    rdy_d = ~sp_vld_d;
  end

  // rdy_q resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sp_q      <= '0;
      sp_vld_q  <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sp_q      <= sp_d;
      sp_vld_q  <= sp_vld_d;
      rdy_q     <= rdy_d;
    end
  end
endmodule

// File: rtl/rmt_pipeline_wrapper.sv
// rmt_pipeline_wrapper: AXI4-Stream packet rewriter, 512-bit data path.
//   Control packets (VLAN/IPv4/UDP to CTRL_UDP_PORT) are swallowed and program
//   a TBL_DEPTH-entry action table from their second beat. Data packets have
//   4 bytes of their first beat overwritten when the entry picked by VID is
//   valid; everything else passes through a 2-entry skid buffer (1 cycle).
//   clk, aresetn       : clock, async active-low reset
//   s_axis_*           : ingress stream (tready out)
//   m_axis_*           : egress stream (tready in)
`timescale 1ns/1ps
module rmt_pipeline_wrapper
  import rmt_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH   = 32,
  parameter int          C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h80000000,
  parameter int          PHV_ADDR_WIDTH       = 4,
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          C_M_AXIS_DATA_WIDTH  = 512,
  parameter int          TBL_DEPTH            = 32,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2
) (
  input  logic                                clk,
  input  logic                                aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast
);
  localparam int IW = $clog2(TBL_DEPTH);

  if (C_S_AXIS_DATA_WIDTH != 512 || C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH ||
      TBL_DEPTH != (1 << IW) || IW > 5) begin : g_bad_cfg
    $error("rmt_pipeline_wrapper: unsupported width/depth configuration");
  end
  // AXI-Lite / PHV parameters are placeholders; only sanity-check them.
  if (C_S_AXI_DATA_WIDTH <= 0 || C_S_AXI_ADDR_WIDTH <= 0 || PHV_ADDR_WIDTH <= 0 ||
      C_BASEADDR[1:0] != 2'b00) begin : g_bad_rsvd
    $error("rmt_pipeline_wrapper: bad reserved parameter");
  end

  logic           first_q, ctrl_q, sec_q;
  logic [7:0]     res_q;
  logic [IW-1:0]  idx_q;
  act_entry_t     tbl_q [TBL_DEPTH];

  logic           in_fire, is_vlan, is_ctrl_hdr, pkt_ctrl, hit;
  logic [IW-1:0]  vid_idx;
  act_entry_t     ent;
  logic [C_S_AXIS_DATA_WIDTH-1:0] wr_data;

  assign in_fire = s_axis_tvalid & s_axis_tready;

  // Header decode only matters on the first beat; later beats use ctrl_q.
  assign is_vlan     = get_byte(s_axis_tdata, TPID_OFF) == 8'h81 &&
                       get_byte(s_axis_tdata, TPID_OFF+1) == 8'h00;
  assign is_ctrl_hdr = is_vlan &&
                       get_byte(s_axis_tdata, ETYPE_OFF) == 8'h08 &&
                       get_byte(s_axis_tdata, ETYPE_OFF+1) == 8'h00 &&
                       get_byte(s_axis_tdata, PROTO_OFF) == 8'h11 &&
                       {get_byte(s_axis_tdata, UDP_DPORT_OFF),
                        get_byte(s_axis_tdata, UDP_DPORT_OFF+1)} == CTRL_UDP_PORT;
  assign pkt_ctrl    = first_q ? is_ctrl_hdr : ctrl_q;

  // Table index is the low VID bits, i.e. the low bits of the second TCI byte.
  assign vid_idx = s_axis_tdata[8*(VID_OFF+1) +: IW];
  assign ent     = tbl_q[vid_idx];
  assign hit     = first_q & is_vlan & ent.valid & (ent.offset <= 6'd60);

  always_comb begin
    wr_data = s_axis_tdata;
    if (hit)
      for (int i = 0; i < 4; i++)
        wr_data[8*(int'(ent.offset)+i) +: 8] = ent.value[8*(3-i) +: 8];
  end

  // Packet position and the control header fields latched from beat 0.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      first_q <= 1'b1;
      ctrl_q  <= 1'b0;
      sec_q   <= 1'b0;
      res_q   <= '0;
      idx_q   <= '0;
    end else if (in_fire) begin
      first_q <= s_axis_tlast;
      sec_q   <= first_q & is_ctrl_hdr & ~s_axis_tlast;
      if (first_q) begin
        ctrl_q <= is_ctrl_hdr;
        res_q  <= get_byte(s_axis_tdata, CTRL_RES_OFF);
        idx_q  <= s_axis_tdata[8*CTRL_IDX_OFF +: IW];
      end
    end
  end

  // sec_q is only ever set inside a control packet, so it alone marks the
  // payload beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
    end else if (in_fire && sec_q && res_q == 8'h00) begin
      tbl_q[idx_q] <= '{valid:  1'b1,
                        offset: s_axis_tdata[5:0],
                        value:  {get_byte(s_axis_tdata, 2), get_byte(s_axis_tdata, 3),
                                 get_byte(s_axis_tdata, 4), get_byte(s_axis_tdata, 5)}};
    end
  end

  axis_if #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) sk_in ();
  axis_if #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) sk_out ();

  // Control beats see the same tready but never enter the buffer.
  assign sk_in.tdata   = wr_data;
  assign sk_in.tkeep   = s_axis_tkeep;
  assign sk_in.tuser   = s_axis_tuser;
  assign sk_in.tlast   = s_axis_tlast;
  assign sk_in.tvalid  = s_axis_tvalid & ~pkt_ctrl;
  assign s_axis_tready = sk_in.tready;

  axis_skid_buffer #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (aresetn),
    .s     (sk_in),
    .m     (sk_out)
  );

  assign m_axis_tdata  = sk_out.tdata;
  assign m_axis_tkeep  = sk_out.tkeep;
  assign m_axis_tuser  = sk_out.tuser;
  assign m_axis_tlast  = sk_out.tlast;
  assign m_axis_tvalid = sk_out.tvalid;
  assign sk_out.tready = m_axis_tready;
endmodule

// File: tb/tb_rmt_pipeline_wrapper.sv
`timescale 1ns/1ps
module tb_rmt_pipeline_wrapper;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.DW(512), .UW(128)) ing ();
  axis_if #(.DW(512), .UW(128)) egr ();

  bit   rdy_mode = 1'b0;
  logic rnd_rdy  = 1'b1;
  logic man_rdy  = 1'b1;
  assign egr.tready = rdy_mode ? rnd_rdy : man_rdy;
  always @(negedge clk) rnd_rdy = ($urandom % 4) != 0;

  rmt_pipeline_wrapper dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(ing.tdata), .s_axis_tkeep(ing.tkeep), .s_axis_tuser(ing.tuser),
    .s_axis_tvalid(ing.tvalid), .s_axis_tready(ing.tready), .s_axis_tlast(ing.tlast),
    .m_axis_tdata(egr.tdata), .m_axis_tkeep(egr.tkeep), .m_axis_tuser(egr.tuser),
    .m_axis_tvalid(egr.tvalid), .m_axis_tready(egr.tready), .m_axis_tlast(egr.tlast)
  );

  int checks = 0, errors = 0, n_out = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       q[$];          // beats currently held inside the DUT, in order
  bit          tv[32];
  logic [5:0]  toff[32];
  logic [31:0] tval[32];
  bit          m_first = 1'b1, m_ctrl = 1'b0, rst_prev = 1'b0;
  int          m_bn = 0;
  logic [7:0]  m_res;
  logic [4:0]  m_idx;

  function automatic logic [7:0] gb(input logic [511:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  task automatic model_in(input logic [511:0] d, input logic [63:0] k,
                          input logic [127:0] u, input logic l);
    beat_t b;
    bit vlan, ctrl;
    logic [7:0] i8;
    logic [31:0] v;
    int o;
    b.d = d; b.k = k; b.u = u; b.l = l;
    if (m_first) begin
      vlan = gb(d, 12) == 8'h81 && gb(d, 13) == 8'h00;
      ctrl = vlan && gb(d, 16) == 8'h08 && gb(d, 17) == 8'h00 && gb(d, 27) == 8'h11 &&
             gb(d, 40) == 8'hF1 && gb(d, 41) == 8'hF2;
      m_ctrl = ctrl;
      m_bn = 0;
      if (ctrl) begin
        m_res = gb(d, 43);
        i8 = gb(d, 44);
        m_idx = i8[4:0];
      end else begin
        i8 = gb(d, 15);
        if (vlan && tv[i8[4:0]] && toff[i8[4:0]] <= 6'd60) begin
          o = int'(toff[i8[4:0]]);
          v = tval[i8[4:0]];
          for (int i = 0; i < 4; i++) b.d[8*(o+i) +: 8] = v[31-8*i -: 8];
        end
        q.push_back(b);
      end
    end else if (m_ctrl) begin
      if (m_bn == 1 && m_res == 8'h00) begin
        tv[m_idx]   = 1'b1;
        toff[m_idx] = d[5:0];
        tval[m_idx] = {gb(d, 2), gb(d, 3), gb(d, 4), gb(d, 5)};
      end
    end else begin
      q.push_back(b);
    end
    m_bn++;
    m_first = l;
  endtask

  // Compare process: checked at negedge+2, when DUT registers and driven
  // inputs are stable; the handshakes seen here are those of the next edge.
  always @(negedge clk) begin
    #2;
    if (!aresetn) begin
      q.delete();
      m_first = 1'b1; m_ctrl = 1'b0; m_bn = 0;
      for (int i = 0; i < 32; i++) tv[i] = 1'b0;
      rst_prev = 1'b0;
    end else begin
      if (rst_prev) begin
        chk("s_tready_vs_occupancy", ing.tready, q.size() < 2);
        chk("m_tvalid_vs_occupancy", egr.tvalid, q.size() > 0);
        if (egr.tvalid && q.size() > 0) begin
          chk("m_tdata", egr.tdata, q[0].d);
          chk("m_tkeep", egr.tkeep, q[0].k);
          chk("m_tuser", egr.tuser, q[0].u);
          chk("m_tlast", egr.tlast, q[0].l);
        end
      end
      if (egr.tvalid && egr.tready && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (ing.tvalid && ing.tready) model_in(ing.tdata, ing.tkeep, ing.tuser, ing.tlast);
      rst_prev = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // kind 0: non-VLAN, 1: VLAN data, 2: control header
  function automatic logic [511:0] mk_first(input logic [511:0] base, input int kind,
                                            input logic [11:0] vid, input logic [7:0] res,
                                            input logic [7:0] idx);
    logic [511:0] d;
    d = base;
    if (kind == 0) begin
      d[8*12 +: 8] = 8'h08; d[8*13 +: 8] = 8'h00;
    end else begin
      d[8*12 +: 8] = 8'h81; d[8*13 +: 8] = 8'h00;
      d[8*14 +: 4] = vid[11:8]; d[8*15 +: 8] = vid[7:0];
      if (kind == 1) d[8*40 +: 8] = 8'h00;
      else begin
        d[8*16 +: 8] = 8'h08; d[8*17 +: 8] = 8'h00; d[8*27 +: 8] = 8'h11;
        d[8*40 +: 8] = 8'hF1; d[8*41 +: 8] = 8'hF2;
        d[8*43 +: 8] = res;   d[8*44 +: 8] = idx;
      end
    end
    return d;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic [127:0] u, input logic l);
    int n;
    n = 0;
    ing.tdata = d; ing.tkeep = k; ing.tuser = u; ing.tlast = l; ing.tvalid = 1'b1;
    #1;
    while (!ing.tready) begin
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_axis_tready stuck at 0 for %0d cycles", n);
        ing.tvalid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    ing.tvalid = 1'b0;
  endtask

  task automatic send_ctrl(input logic [7:0] res, input logic [7:0] idx, input logic [5:0] off,
                           input logic [31:0] val, input int nb, input bit gaps);
    logic [511:0] c;
    for (int b = 0; b < nb; b++) begin
      c = rnd512();
      if (b == 0) c = mk_first(c, 2, 12'($urandom), res, idx);
      if (b == 1) begin
        c[5:0] = off;
        c[8*2 +: 8] = val[31:24]; c[8*3 +: 8] = val[23:16];
        c[8*4 +: 8] = val[15:8];  c[8*5 +: 8] = val[7:0];
      end
      send_beat(c, '1, {4{$urandom}}, b == nb - 1);
      if (gaps && ($urandom % 4) == 0) @(negedge clk);
    end
  endtask

  task automatic send_data(input int kind, input logic [11:0] vid, input int nb, input bit gaps);
    logic [511:0] d;
    for (int b = 0; b < nb; b++) begin
      d = rnd512();
      if (b == 0) d = mk_first(d, kind, vid, 8'h00, 8'h00);
      send_beat(d, (b == nb - 1) ? 64'({$urandom, $urandom}) : '1, {4{$urandom}}, b == nb - 1);
      if (gaps && ($urandom % 4) == 0) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d, e;
    logic [63:0]  k;
    logic [127:0] u;
    int n0, n;
    ing.tdata = '0; ing.tkeep = '0; ing.tuser = '0; ing.tlast = 1'b0; ing.tvalid = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_m_tvalid", egr.tvalid, 0);
    chk("rst_m_tdata", egr.tdata, 0);
    chk("rst_m_tkeep", egr.tkeep, 0);
    chk("rst_m_tuser", egr.tuser, 0);
    chk("rst_m_tlast", egr.tlast, 0);
    @(negedge clk); aresetn = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_s_tready", ing.tready, 1);
    chk("post_rst_m_tvalid", egr.tvalid, 0);

    // Passthrough of a 2-beat non-VLAN packet, 1 cycle latency
    d = mk_first(rnd512(), 0, 12'h0, 8'h0, 8'h0); u = {4{$urandom}};
    send_beat(d, '1, u, 1'b0); #1;
    chk("pt_b0_valid", egr.tvalid, 1);
    chk("pt_b0_data", egr.tdata, d);
    chk("pt_b0_user", egr.tuser, u);
    chk("pt_b0_last", egr.tlast, 0);
    d = rnd512(); k = 64'h0000_0000_00FF_FFFF; u = {4{$urandom}};
    send_beat(d, k, u, 1'b1); #1;
    chk("pt_b1_data", egr.tdata, d);
    chk("pt_b1_keep", egr.tkeep, k);
    chk("pt_b1_user", egr.tuser, u);
    chk("pt_b1_last", egr.tlast, 1);

    // Program entry 1 (offset 8, value 0B910C23), data packet back-to-back
    send_ctrl(8'h00, 8'h01, 6'd8, 32'h0B910C23, 1, 1'b0); #1;
    chk("ctrl_not_forwarded", egr.tvalid, 0);
    send_ctrl(8'h00, 8'h01, 6'd8, 32'h0B910C23, 2, 1'b0);
    d = mk_first(rnd512(), 1, 12'h001, 8'h0, 8'h0);
    e = d;
    e[8*8 +: 8] = 8'h0B; e[8*9 +: 8] = 8'h91; e[8*10 +: 8] = 8'h0C; e[8*11 +: 8] = 8'h23;
    send_beat(d, '1, '0, 1'b1); #1;
    chk("hit_valid", egr.tvalid, 1);
    chk("hit_rewrite", egr.tdata, e);

    // Miss: VID 2 never written
    d = mk_first(rnd512(), 1, 12'h002, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("miss_vid2", egr.tdata, d);
    // Offset 61 is out of range
    send_ctrl(8'h00, 8'h03, 6'd61, 32'hDEADBEEF, 2, 1'b0);
    d = mk_first(rnd512(), 1, 12'h003, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("off61_unmod", egr.tdata, d);
    // 1-beat control packet writes nothing
    send_ctrl(8'h00, 8'h04, 6'd0, 32'h11223344, 1, 1'b0);
    d = mk_first(rnd512(), 1, 12'h004, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("short_ctrl_unmod", egr.tdata, d);
    // Resource id 0x0F writes nothing
    send_ctrl(8'h0F, 8'h05, 6'd0, 32'h55667788, 2, 1'b0);
    d = mk_first(rnd512(), 1, 12'h005, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("res0f_unmod", egr.tdata, d);
    // Upper VID bits do not matter: 0xA21 selects entry 1
    d = mk_first(rnd512(), 1, 12'hA21, 8'h0, 8'h0);
    e = d;
    e[8*8 +: 8] = 8'h0B; e[8*9 +: 8] = 8'h91; e[8*10 +: 8] = 8'h0C; e[8*11 +: 8] = 8'h23;
    send_beat(d, '1, '0, 1'b1); #1;
    chk("hit_vid_a21", egr.tdata, e);

    // Backpressure: 3-beat packet, m_axis_tready low for 3 cycles mid-packet
    @(negedge clk);
    n0 = n_out;
    send_data(0, 12'h0, 1, 1'b0);
    d = mk_first(rnd512(), 0, 12'h0, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b0);
    man_rdy = 1'b0;
    fork begin repeat (3) @(negedge clk); man_rdy = 1'b1; end join_none
    send_beat(rnd512(), '1, '0, 1'b0); #1;
    chk("bp_spare_full_tready", ing.tready, 0);
    send_beat(rnd512(), '1, '0, 1'b1);
    repeat (4) @(negedge clk);
    chk("bp_beats_out", n_out - n0, 4);

    // Reset mid-control-packet discards it and clears the table
    man_rdy = 1'b0;
    send_data(0, 12'h0, 1, 1'b0);
    send_ctrl(8'h00, 8'h06, 6'd0, 32'h0, 1, 1'b0);
    d = mk_first(rnd512(), 2, 12'h0, 8'h00, 8'h06);
    send_beat(d, '1, '0, 1'b0);
    aresetn = 1'b0; #1;
    chk("midrst_m_tvalid", egr.tvalid, 0);
    chk("midrst_m_tdata", egr.tdata, 0);
    @(negedge clk); aresetn = 1'b1; man_rdy = 1'b1;
    @(negedge clk);
    d = mk_first(rnd512(), 0, 12'h0, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("midrst_first_beat", egr.tdata, d);
    chk("midrst_first_valid", egr.tvalid, 1);
    d = mk_first(rnd512(), 1, 12'h001, 8'h0, 8'h0);
    send_beat(d, '1, '0, 1'b1); #1;
    chk("tbl_cleared", egr.tdata, d);

    // Randomized traffic with random backpressure
    @(negedge clk); rdy_mode = 1'b1;
    for (int p = 0; p < 300; p++) begin
      case ($urandom % 3)
        0: send_data(0, 12'h0, 1 + $urandom % 4, 1'b1);
        1: send_data(1, 12'($urandom), 1 + $urandom % 4, 1'b1);
        default: send_ctrl((($urandom % 4) == 0) ? 8'($urandom) : 8'h00, 8'($urandom),
                           6'($urandom), $urandom, 1 + $urandom % 3, 1'b1);
      endcase
    end
    @(negedge clk); rdy_mode = 1'b0; man_rdy = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    #3;
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
